// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD compute tile.
//   gcd_state_t : engine FSM encoding, also exported on the debug port
//   MODE_SUB    : repeated-subtraction algorithm
//   MODE_BIN    : binary (Stein) algorithm
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NORM = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } gcd_state_t;

  localparam int MODE_SUB = 0;
  localparam int MODE_BIN = 1;

endpackage

// File: rtl/gcd_step.sv
// One CALC iteration of the GCD reduction, purely combinational.
// Ports:
//   a_i, b_i : current operand registers
//   a_o, b_o : operand values after this iteration
//   eq_o     : reduction finished (MODE_SUB: a==b; MODE_BIN: both odd and a==b)
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = MODE_SUB
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             eq_o
);

  logic             a_gt;
  logic             a_eq;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;

  // Both differences are formed, but only the larger-minus-smaller one is
  // ever selected, so the result never wraps.
  assign a_gt    = (a_i > b_i);
  assign a_eq    = (a_i == b_i);
  assign diff_ab = a_i - b_i;
  assign diff_ba = b_i - a_i;

  always_comb begin
    a_o  = a_i;
    b_o  = b_i;
    eq_o = 1'b0;
    if (MODE == MODE_SUB) begin
      eq_o = a_eq;
      if (a_gt) begin
        a_o = diff_ab;
      end else if (!a_eq) begin
        b_o = diff_ba;
      end
    end else begin
      // Stein: strip factors of two first, then subtract odd from odd; the
      // difference of two odd numbers is even, so it is halved immediately.
      if (!a_i[0]) begin
        a_o = a_i >> 1;
      end else if (!b_i[0]) begin
        b_o = b_i >> 1;
      end else if (a_eq) begin
        eq_o = 1'b1;
      end else if (a_gt) begin
        a_o = diff_ab >> 1;
      end else begin
        b_o = diff_ba >> 1;
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// GCD compute tile: FSM, operand registers and iteration counter.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the source holds its data stable until then, the sink may raise
// ready independently, and valid is never withdrawn before the transfer.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake; in_a/in_b operands
//   abort                 : cancel a running job (NORM/CALC/FIX), no result
//   out_valid/out_ready   : result handshake; out_gcd result
//   out_cycles            : NORM/CALC/FIX cycles spent on the job, saturating
//   dbg_state             : current FSM state for observation
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = MODE_SUB,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CNT_W-1:0] out_cycles,
  output gcd_state_t       dbg_state
);

  localparam int K_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [K_W-1:0]   K_ONE   = {{(K_W-1){1'b0}}, 1'b1};

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;

  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;
  logic             step_eq;
  logic [CNT_W-1:0] cnt_inc;
  logic             busy;

  gcd_step #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_step (
    .a_i  (a_q),
    .b_i  (b_q),
    .a_o  (step_a),
    .b_o  (step_b),
    .eq_o (step_eq)
  );

  // Count including the current cycle; out_cycles captures this value so the
  // cycle that enters DONE is itself counted.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign busy    = (state_q == NORM) || (state_q == CALC) || (state_q == FIX);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    gcd_d   = gcd_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if ((in_a == '0) || (in_b == '0)) begin
            // gcd(x,0)=x and gcd(0,0)=0: no iterations needed.
            gcd_d   = in_a | in_b;
            cyc_d   = '0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            a_d     = in_a;
            b_d     = in_b;
            k_d     = '0;
            cnt_d   = '0;
            state_d = (MODE == MODE_BIN) ? NORM : CALC;
          end
        end
      end

      NORM: begin
        cnt_d = cnt_inc;
        if (!a_q[0] && !b_q[0]) begin
          // Common factor of two, restored by the shift in FIX.
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + K_ONE;
        end else begin
          state_d = CALC;
        end
      end

      CALC: begin
        cnt_d = cnt_inc;
        a_d   = step_a;
        b_d   = step_b;
        if (step_eq) begin
          if (MODE == MODE_BIN) begin
            state_d = FIX;
          end else begin
            gcd_d   = a_q;
            cyc_d   = cnt_inc;
            state_d = DONE;
          end
        end
      end

      FIX: begin
        cnt_d   = cnt_inc;
        gcd_d   = a_q << k_q;
        cyc_d   = cnt_inc;
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort beats any same-cycle move to DONE and leaves the result
    // registers untouched.
    if (abort && busy) begin
      state_d = IDLE;
      gcd_d   = gcd_q;
      cyc_d   = cyc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      gcd_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      gcd_q   <= gcd_d;
    end
  end

  assign in_ready   = rst_n && (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_gcd    = gcd_q;
  assign out_cycles = cyc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: three instances share clock and reset.
//   index 0 : MODE_SUB, CNT_W=16
//   index 1 : MODE_BIN, CNT_W=16
//   index 2 : MODE_SUB, CNT_W=4 (saturation of out_cycles)
module tb_gcd_engine;
  import gcd_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv[3];
  logic         abt[3];
  logic         ordy[3];
  logic         ir[3];
  logic         ov[3];
  logic [W-1:0] ia[3];
  logic [W-1:0] ib[3];
  logic [W-1:0] og[3];
  logic [W-1:0] oc[3];
  logic [3:0]   oc2;
  gcd_state_t   st[3];

  int checks = 0;
  int errors = 0;

  gcd_engine #(.WIDTH(W), .MODE(0), .CNT_W(16)) u_sub (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia[0]), .in_b(ib[0]), .abort(abt[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_gcd(og[0]), .out_cycles(oc[0]), .dbg_state(st[0])
  );

  gcd_engine #(.WIDTH(W), .MODE(1), .CNT_W(16)) u_bin (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[1]), .in_b(ib[1]), .abort(abt[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_gcd(og[1]), .out_cycles(oc[1]), .dbg_state(st[1])
  );

  gcd_engine #(.WIDTH(W), .MODE(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(ia[2]), .in_b(ib[2]), .abort(abt[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_gcd(og[2]), .out_cycles(oc2), .dbg_state(st[2])
  );
  assign oc[2] = {12'd0, oc2};

  // Reference: Euclid with division.
  function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Subtractive iteration count = sum of Euclid quotients (each quotient q is
  // q subtractions, except the last which is q-1 subtractions plus the
  // equality cycle).
  function automatic int unsigned ref_sub_cycles(input int unsigned x, input int unsigned y);
    int unsigned hi, lo, r, s;
    if (x == 0 || y == 0) return 0;
    hi = (x > y) ? x : y;
    lo = (x > y) ? y : x;
    s  = 0;
    while (lo != 0) begin
      s += hi / lo;
      r  = hi % lo;
      hi = lo;
      lo = r;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Run one job on instance d; optionally hold out_ready low for `hold`
  // cycles and/or wiggle in_valid with other operands while busy.
  task automatic run_job(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input bit noise);
    int          lat;
    int unsigned raw, cmax, eg;
    eg   = ref_gcd(a, b);
    raw  = ref_sub_cycles(a, b);
    cmax = (d == 2) ? 15 : 65535;
    lat  = 0;
    while (!ir[d] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("ready_before", ir[d], 1);
    iv[d] = 1'b1;
    ia[d] = a;
    ib[d] = b;
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    if (noise) begin
      iv[d] = 1'b1;
      ia[d] = ~a;
      ib[d] = b ^ 16'h00ff;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) iv[d] = 1'b0;
    end while (!ov[d] && lat < 70000);
    iv[d] = 1'b0;
    chk("out_valid_seen", ov[d], 1);
    chk("busy_ready_low", ir[d], 0);
    chk("gcd", og[d], eg);
    if (d == 1) begin
      chk("latency_bin", lat, oc[d] + 1);
      chk("cycles_zero_bin", (oc[d] == 0), (a == 0 || b == 0));
    end else begin
      chk("cycles", oc[d], (raw > cmax) ? cmax : raw);
      chk("latency", lat, raw + 1);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", ov[d], 1);
      chk("hold_gcd", og[d], eg);
      chk("hold_ready", ir[d], 0);
    end
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    @(negedge clk);
    chk("valid_drop", ov[d], 0);
    chk("ready_rise", ir[d], 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; abt[i] = 1'b0; ordy[i] = 1'b0; ia[i] = '0; ib[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", ir[i], 0);
      chk("rst_out_valid", ov[i], 0);
      chk("rst_out_gcd", og[i], 0);
      chk("rst_out_cycles", oc[i], 0);
      chk("rst_state", st[i], IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("post_rst_ready", ir[i], 1);

    // Directed cases
    run_job(0, 16'd48, 16'd18, 0, 1'b0);
    run_job(1, 16'd48, 16'd18, 0, 1'b0);
    run_job(0, 16'd0, 16'd7, 0, 1'b0);
    run_job(1, 16'd0, 16'd7, 0, 1'b0);
    run_job(0, 16'd0, 16'd0, 0, 1'b0);
    run_job(1, 16'd0, 16'd0, 0, 1'b0);
    run_job(0, 16'd13, 16'd13, 0, 1'b0);
    run_job(0, 16'd65535, 16'd65534, 0, 1'b0);
    run_job(1, 16'd65535, 16'd65534, 0, 1'b0);
    run_job(2, 16'd1, 16'd40, 0, 1'b0);
    run_job(2, 16'd12, 16'd8, 0, 1'b0);
    run_job(0, 16'd48, 16'd18, 5, 1'b0);
    run_job(1, 16'd96, 16'd40, 5, 1'b0);
    run_job(0, 16'd48, 16'd18, 0, 1'b1);
    run_job(1, 16'd1024, 16'd768, 0, 1'b1);

    // Abort in the third CALC cycle
    @(negedge clk);
    iv[0] = 1'b1; ia[0] = 16'd48; ib[0] = 16'd18;
    @(posedge clk); #1; iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1; abt[0] = 1'b1;
    @(negedge clk);
    chk("abort_pre_state", st[0], CALC);
    @(posedge clk); #1; abt[0] = 1'b0;
    @(negedge clk);
    chk("abort_ready", ir[0], 1);
    chk("abort_state", st[0], IDLE);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_valid", ov[0], 0);
      @(negedge clk);
    end

    // Abort beats the same-cycle CALC->DONE move
    iv[0] = 1'b1; ia[0] = 16'd13; ib[0] = 16'd13;
    @(posedge clk); #1; iv[0] = 1'b0; abt[0] = 1'b1;
    @(posedge clk); #1; abt[0] = 1'b0;
    @(negedge clk);
    chk("abort_eq_no_valid", ov[0], 0);
    chk("abort_eq_ready", ir[0], 1);

    // Abort during NORM on the binary engine
    iv[1] = 1'b1; ia[1] = 16'd48; ib[1] = 16'd18;
    @(posedge clk); #1; iv[1] = 1'b0; abt[1] = 1'b1;
    @(negedge clk);
    chk("abort_norm_state", st[1], NORM);
    @(posedge clk); #1; abt[1] = 1'b0;
    @(negedge clk);
    chk("abort_norm_ready", ir[1], 1);
    chk("abort_norm_no_valid", ov[1], 0);

    run_job(0, 16'd21, 16'd14, 0, 1'b0);

    // Reset in the middle of CALC
    iv[0] = 1'b1; ia[0] = 16'd200; ib[0] = 16'd3;
    @(posedge clk); #1; iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", st[0], CALC);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_valid", ov[0], 0);
    chk("midrst_gcd", og[0], 0);
    chk("midrst_cycles", oc[0], 0);
    chk("midrst_ready", ir[0], 0);
    chk("midrst_state", st[0], IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", ir[0], 1);

    // Randomized jobs
    for (int n = 0; n < 25; n++) begin
      run_job(0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), $urandom_range(0, 2), 1'b0);
    end
    for (int n = 0; n < 40; n++) begin
      run_job(1, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 10; n++) begin
      run_job(2, W'($urandom_range(1, 60)), W'($urandom_range(1, 60)), 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
